// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of physical registers with speculative and architectural heads
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 2
`endif

module free_list #(
    parameter int PHY_REG_NUM  = 64,
    parameter int DECODE_WIDTH = `DECODE_WIDTH,
    parameter int COMMIT_WIDTH = `COMMIT_WIDTH,
    localparam int PW = $clog2(PHY_REG_NUM),
    localparam int CW = PW + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 alloc_valid_i,
    input  logic [DECODE_WIDTH-1:0]              alloc_req_i,
    output logic                                 alloc_ready_o,
    output logic [DECODE_WIDTH-1:0][PW-1:0]      preg_o,
    input  logic [COMMIT_WIDTH-1:0]              commit_alloc_i,
    input  logic [COMMIT_WIDTH-1:0]              free_i,
    input  logic [COMMIT_WIDTH-1:0][PW-1:0]      free_preg_i,
    input  logic                                 restore_i,
    output logic [CW-1:0]                        free_cnt_o
);

    logic [PW-1:0] entry_q [PHY_REG_NUM];
    logic [PW-1:0] entry_d [PHY_REG_NUM];
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW-1:0] arch_head_q, arch_head_d;
    logic [CW-1:0] alloc_n, free_n, commit_n;
    logic [PW-1:0] ridx, widx;
    logic          fire;

    always_comb begin
        free_cnt_o    = tail_q - head_q;
        alloc_ready_o = !restore_i && (free_cnt_o >= CW'(DECODE_WIDTH));
        fire          = alloc_valid_i && alloc_ready_o;

        // Requesting lanes take consecutive entries from head, in lane order
        alloc_n = '0;
        ridx    = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            preg_o[i] = '0;
            if (alloc_req_i[i]) begin
                ridx      = head_q[PW-1:0] + alloc_n[PW-1:0];
                preg_o[i] = entry_q[ridx];
                alloc_n   = alloc_n + CW'(1);
            end
        end

        entry_d = entry_q;
        free_n  = '0;
        widx    = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            if (free_i[j]) begin
                widx          = tail_q[PW-1:0] + free_n[PW-1:0];
                entry_d[widx] = free_preg_i[j];
                free_n        = free_n + CW'(1);
            end
        end

        commit_n = '0;
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            commit_n = commit_n + CW'(commit_alloc_i[j]);
        end

        arch_head_d = arch_head_q + commit_n;
        tail_d      = tail_q + free_n;
        // A flush rewinds to the architectural head including this cycle's commits
        if (restore_i) begin
            head_d = arch_head_d;
        end else if (fire) begin
            head_d = head_q + alloc_n;
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            arch_head_q <= '0;
            tail_q      <= CW'(PHY_REG_NUM - 1);
            for (int k = 0; k < PHY_REG_NUM; k++) begin
                entry_q[k] <= (k == PHY_REG_NUM - 1) ? '0 : PW'(k + 1);
            end
        end else begin
            head_q      <= head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            entry_q     <= entry_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed and scoreboarded checks of free_list
module tb_free_list;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            alloc_valid = 1'b0;
    logic [3:0]      alloc_req = '0;
    logic            alloc_ready;
    logic [3:0][5:0] preg;
    logic [1:0]      commit_alloc = '0;
    logic [1:0]      free_v = '0;
    logic [1:0][5:0] free_preg = '0;
    logic            restore = 1'b0;
    logic [6:0]      free_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    int   fl[$];
    bit   live[64];
    logic [3:0] rq;
    logic       av;
    int   k, p, tries;

    always #5 clk = ~clk;

    free_list #(.PHY_REG_NUM(64), .DECODE_WIDTH(4), .COMMIT_WIDTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_valid_i  (alloc_valid),
        .alloc_req_i    (alloc_req),
        .alloc_ready_o  (alloc_ready),
        .preg_o         (preg),
        .commit_alloc_i (commit_alloc),
        .free_i         (free_v),
        .free_preg_i    (free_preg),
        .restore_i      (restore),
        .free_cnt_o     (free_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset values, checked while reset is still asserted
        #2 rst_n = 1'b0;
        alloc_req = 4'b1111;
        #1;
        check("rst_cnt", free_cnt, 63);
        check("rst_ready", alloc_ready, 1);
        check("rst_lane0", preg[0], 1);
        check("rst_lane1", preg[1], 2);
        check("rst_lane2", preg[2], 3);
        check("rst_lane3", preg[3], 4);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_cnt", free_cnt, 63);

        // compacted allocation 4'b1011
        alloc_valid = 1'b1;
        alloc_req = 4'b1011;
        #1;
        check("cmp_lane0", preg[0], 1);
        check("cmp_lane1", preg[1], 2);
        check("cmp_lane2", preg[2], 0);
        check("cmp_lane3", preg[3], 3);
        tick();
        alloc_valid = 1'b0;
        alloc_req = 4'b0001;
        #1;
        check("cmp_next_cnt", free_cnt, 60);
        check("cmp_next_lane0", preg[0], 4);

        // preg 9 freed while allocating is not forwarded
        alloc_valid = 1'b1;
        alloc_req = 4'b1111;
        tick();
        tick();
        free_v = 2'b01;
        free_preg[0] = 6'd9;
        #1;
        check("fwd_lane0", preg[0], 12);
        check("fwd_lane3", preg[3], 15);
        tick();
        free_v = 2'b00;
        check("fwd_cnt", free_cnt, 49);
        for (int g = 0; g < 12; g++) begin
            check("drain_lane0", preg[0], 16 + 4 * g);
            tick();
        end
        check("wrap_cnt", free_cnt, 1);
        check("wrap_ready", alloc_ready, 0);
        check("wrap_preg9", preg[0], 9);
        tick();
        check("noop_cnt", free_cnt, 1);
        check("noop_preg9", preg[0], 9);

        // asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        check("async_cnt", free_cnt, 63);
        check("async_lane0", preg[0], 1);
        check("async_ready", alloc_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // drain to 3 free, then one free re-enables allocation
        for (int g = 0; g < 15; g++) tick();
        check("low_cnt", free_cnt, 3);
        check("low_ready", alloc_ready, 0);
        check("low_lane0", preg[0], 61);
        tick();
        check("low_hold_cnt", free_cnt, 3);
        check("low_hold_lane0", preg[0], 61);
        free_v = 2'b01;
        free_preg[0] = 6'd5;
        #1;
        check("low_same_ready", alloc_ready, 0);
        tick();
        free_v = 2'b00;
        #1;
        check("low_free_ready", alloc_ready, 1);
        check("low_free_cnt", free_cnt, 4);

        // allocate 8, commit 3 (with one free), then restore
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        alloc_valid = 1'b1;
        alloc_req = 4'b1111;
        tick();
        tick();
        alloc_valid = 1'b0;
        commit_alloc = 2'b11;
        free_v = 2'b01;
        free_preg[0] = 6'd2;
        tick();
        commit_alloc = 2'b01;
        free_v = 2'b00;
        tick();
        commit_alloc = 2'b00;
        restore = 1'b1;
        alloc_valid = 1'b1;
        #1;
        check("rest_ready", alloc_ready, 0);
        tick();
        restore = 1'b0;
        alloc_valid = 1'b0;
        alloc_req = 4'b0001;
        #1;
        check("rest_cnt", free_cnt, 61);
        check("rest_lane0", preg[0], 4);

        // restore, commit 2 and free 1 in the same cycle
        restore = 1'b1;
        commit_alloc = 2'b11;
        free_v = 2'b01;
        free_preg[0] = 6'd3;
        alloc_valid = 1'b1;
        alloc_req = 4'b1111;
        #1;
        check("combo_ready", alloc_ready, 0);
        tick();
        restore = 1'b0;
        commit_alloc = 2'b00;
        free_v = 2'b00;
        #1;
        check("combo_cnt", free_cnt, 60);
        check("combo_lane0", preg[0], 6);
        check("combo_lane3", preg[3], 9);
        alloc_valid = 1'b0;
        restore = 1'b1;
        tick();
        restore = 1'b0;
        #1;
        check("combo_arch_lane0", preg[0], 6);
        check("combo_arch_cnt", free_cnt, 60);

        // random alloc/free against a queue scoreboard
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        fl.delete();
        for (int i = 1; i < 64; i++) fl.push_back(i);
        for (int i = 0; i < 64; i++) live[i] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            rq = 4'($urandom_range(0, 15));
            av = ($urandom_range(0, 3) != 0);
            free_v = 2'b00;
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 1) == 1) begin
                    for (tries = 0; tries < 8; tries++) begin
                        p = $urandom_range(1, 63);
                        if (live[p] && !(l == 1 && free_v[0] && free_preg[0] == 6'(p))) begin
                            free_v[l] = 1'b1;
                            free_preg[l] = 6'(p);
                            break;
                        end
                    end
                end
            end
            alloc_valid = av;
            alloc_req = rq;
            #1;
            check("rnd_cnt", free_cnt, fl.size());
            check("rnd_ready", alloc_ready, fl.size() >= 4);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (rq[i]) begin
                    if (k < fl.size()) begin
                        check("rnd_lane", preg[i], fl[k]);
                        check("rnd_not_live", live[preg[i]], 0);
                    end
                    k++;
                end else begin
                    check("rnd_idle_lane", preg[i], 0);
                end
            end
            tick();
            if (av && fl.size() >= 4) begin
                for (int i = 0; i < 4; i++) begin
                    if (rq[i]) live[fl.pop_front()] = 1'b1;
                end
            end
            for (int l = 0; l < 2; l++) begin
                if (free_v[l]) begin
                    fl.push_back(int'(free_preg[l]));
                    live[free_preg[l]] = 1'b0;
                end
            end
        end
        alloc_valid = 1'b0;
        free_v = 2'b00;
        #1;
        check("rnd_final_cnt", free_cnt, fl.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
